rx_word_assembler: RTL and testbench
====================================

// Module: rx_word_assembler
// PURPOSE
//   Receive-side counterpart of the 2-byte UART word sender. Takes bytes from the UART receiver
//   (rx_ready strobe + rx_data) and rebuilds 16-bit words sent low byte first.
//   Emits a one-cycle word_valid pulse per completed word.
//   Drops a half-received word if the high byte does not arrive within TIMEOUT_CYCLES.
// PARAMETERS
//   TIMEOUT_CYCLES  1_000_000  max clk cycles from low-byte capture to high-byte strobe (>=2)
//   CNT_W           $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, not overridden)
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   reset        in   1   synchronous, active-high
//   rx_ready     in   1   1-cycle strobe from UART receiver: rx_data holds a new byte
//   rx_data      in   8   received byte, valid only while rx_ready=1
//   word_data    out  16  last completed word {high,low}; held until next completed word
//   word_valid   out  1   1-cycle pulse: word_data updated this cycle
//   timeout_err  out  1   1-cycle pulse: partial word discarded on timeout
//   busy         out  1   1 while a low byte is held awaiting its high byte
//   word_count   out  8   number of completed words since reset, wraps 255->0
//   state_id     out  2   debug: current state encoding (IDLE=0, WAIT_HIGH=1)
// BEHAVIOUR
//   Reset: state=IDLE; word_data=16'h0000, word_valid=0, timeout_err=0, busy=0,
//     word_count=0, timer=0, low-byte reg=0.
//   Reset has priority over everything. A partial word held at reset is discarded, and no pulse is emitted.
//   All outputs are registered. FSM: IDLE, WAIT_HIGH.
//   IDLE:
//     - rx_ready=1 -> low_reg<=rx_data, timer<=0, state<=WAIT_HIGH.
//     - busy=1 from the next cycle.
//   WAIT_HIGH, each cycle, in priority order:
//     - rx_ready=1 -> word_data<={rx_data,low_reg}, word_valid<=1, word_count<=word_count+1,
//       state<=IDLE.
//     - else if timer==TIMEOUT_CYCLES-1 -> timeout_err<=1, state<=IDLE; low_reg is not forwarded.
//     - else timer<=timer+1.
//   Latency: word_valid is high in the cycle after the high-byte rx_ready edge.
//   Simultaneous high-byte strobe and timer expiry: the byte wins, so no timeout_err fires.
//   Back-to-back: an rx_ready in the cycle word_valid or timeout_err is high is
//     taken as a new low byte (IDLE accepts it). No dead cycles, no byte dropped.
//   rx_data is ignored whenever rx_ready=0. word_valid and timeout_err are never high together.
//   word_count is 8-bit modulo: it wraps silently, with no flag.
//   busy==(state==WAIT_HIGH); state_id mirrors state.
// TESTING (bench uses TIMEOUT_CYCLES=100)
//   1. Basic word: rx_ready with 8'h34, 5 idle cycles, then rx_ready with 8'h12
//      -> next cycle word_valid=1, word_data=16'h1234, word_count=1.
//   2. Back-to-back: strobes A5,5A,FF,00 on 4 consecutive cycles
//      -> word_valid pulses twice (16'h5AA5, then 16'h00FF); busy toggles 1,0,1,0.
//   3. Timeout: rx_ready 8'h77, then 100 quiet cycles
//      -> timeout_err=1 for 1 cycle, busy=0, word_data unchanged, word_count unchanged.
//      A following pair 01,02 yields 16'h0201.
//   4. Expiry race: high-byte strobe exactly in the cycle timer==99
//      -> word_valid=1, timeout_err stays 0.
//   5. Reset mid-word: rx_ready 8'hAB, then reset for 1 cycle
//      -> all outputs back to reset values. Next strobes CD,EF give 16'hEFCD, not 16'hCDAB.
//   6. Wrap: 256 complete words -> word_count returns to 8'h00 and no error.

Source files
------------

// File: rtl/rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_assembler
// Description : Rebuilds 16-bit words (low byte first) from UART receiver
//               bytes, discarding a half word if its high byte times out.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_assembler #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic [15:0] word_data,
  output logic        word_valid,
  output logic        timeout_err,
  output logic        busy,
  output logic [7:0]  word_count,
  output logic [1:0]  state_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_timer_last = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_HIGH = 1'b1
  } state_t;

  state_t             r_state;
  logic [7:0]         r_low;
  logic [CNT_W-1:0]   r_timer;
  logic [15:0]        r_word_data;
  logic               r_word_valid;
  logic               r_timeout_err;
  logic               r_busy;
  logic [7:0]         r_word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_low         <= 8'h00;
      r_timer       <= '0;
      r_word_data   <= 16'h0000;
      r_word_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
      r_word_count  <= 8'h00;
    end else begin
      r_word_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_low   <= rx_data;
            r_timer <= '0;
            r_state <= S_WAIT_HIGH;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // A high byte arriving on the expiry cycle still completes the word.
          if (rx_ready) begin
            r_word_data  <= {rx_data, r_low};
            r_word_valid <= 1'b1;
            r_word_count <= r_word_count + 8'd1;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else if (r_timer == c_timer_last) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign word_data   = r_word_data;
  assign word_valid  = r_word_valid;
  assign timeout_err = r_timeout_err;
  assign busy        = r_busy;
  assign word_count  = r_word_count;
  assign state_id    = {1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_word_assembler
// Description : Scoreboard bench for rx_word_assembler with TIMEOUT_CYCLES=100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_word_assembler;

  localparam int TIMEOUT_CYCLES = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] word_data;
  logic        word_valid;
  logic        timeout_err;
  logic        busy;
  logic [7:0]  word_count;
  logic [1:0]  state_id;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;
  logic [15:0] last_word = 16'h0000;
  logic [7:0]  exp_count = 8'h00;

  rx_word_assembler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .word_data(word_data), .word_valid(word_valid), .timeout_err(timeout_err),
    .busy(busy), .word_count(word_count), .state_id(state_id)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then leave outputs ready to sample 1 ns after the edge.
  task automatic cycle(input logic rdy, input logic [7:0] d);
    rx_ready = rdy;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h99);
    reset = 1'b0;
    exp_count = 8'h00;
    last_word = 16'h0000;
    checks++; if (word_data !== 16'h0000) begin errors++; $display("FAIL reset_word_data got=%h exp=%h", word_data, 16'h0000); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (word_count !== 8'h00) begin errors++; $display("FAIL reset_word_count got=%h exp=00", word_count); end
    checks++; if (state_id !== 2'd0) begin errors++; $display("FAIL reset_state_id got=%0d exp=0", state_id); end
  endtask

  task automatic test_basic();
    int early;
    early = 0;
    cycle(1'b1, 8'h34);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (state_id !== 2'd1) begin errors++; $display("FAIL basic_state_id got=%0d exp=1", state_id); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'($urandom));
      if (word_valid !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL basic_idle_gap got=%0d bad cycles exp=0", early); end
    exp_q.push_back(16'h1234);
    cycle(1'b1, 8'h12);
    exp_count++;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
    else begin
      exp_word = exp_q.pop_front();
      last_word = exp_word;
      checks++; if (word_data !== exp_word) begin errors++; $display("FAIL basic_data got=%h exp=%h", word_data, exp_word); end
    end
    checks++; if (word_count !== exp_count) begin errors++; $display("FAIL basic_count got=%h exp=%h", word_count, exp_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    cycle(1'b0, 8'h00);
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", word_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic       exp_busy [4];
    bytes = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    exp_busy = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_q.push_back(16'h5AA5);
    exp_q.push_back(16'h00FF);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bytes[i]);
      checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy, exp_busy[i]); end
      checks++; if (word_valid !== ~exp_busy[i]) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, word_valid, ~exp_busy[i]); end
      if (word_valid === 1'b1 && exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        last_word = exp_word;
        exp_count++;
        checks++; if (word_data !== exp_word) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, word_data, exp_word); end
      end
    end
    checks++; if (word_count !== 8'd3) begin errors++; $display("FAIL b2b_count got=%h exp=03", word_count); end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    cycle(1'b1, 8'h77);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      cycle(1'b0, 8'($urandom));
      if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got=%0d bad cycles exp=0", early); end
    cycle(1'b0, 8'h00);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse got=%b exp=1", timeout_err); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid got=%b exp=0", word_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++; if (word_data !== last_word) begin errors++; $display("FAIL timeout_data got=%h exp=%h", word_data, last_word); end
    checks++; if (word_count !== exp_count) begin errors++; $display("FAIL timeout_count got=%h exp=%h", word_count, exp_count); end
    // New low byte taken in the very cycle timeout_err is high.
    exp_q.push_back(16'h0201);
    cycle(1'b1, 8'h01);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got=%b exp=0", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_rearm_busy got=%b exp=1", busy); end
    cycle(1'b1, 8'h02);
    exp_count++;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL timeout_next_valid got=%b exp=1", word_valid); end
    else begin
      exp_word = exp_q.pop_front();
      last_word = exp_word;
      checks++; if (word_data !== exp_word) begin errors++; $display("FAIL timeout_next_data got=%h exp=%h", word_data, exp_word); end
    end
  endtask

  task automatic test_expiry_race();
    cycle(1'b1, 8'h11);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) cycle(1'b0, 8'($urandom));
    exp_q.push_back(16'h2211);
    cycle(1'b1, 8'h22);
    exp_count++;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL race_valid got=%b exp=1", word_valid); end
    else begin
      exp_word = exp_q.pop_front();
      last_word = exp_word;
      checks++; if (word_data !== exp_word) begin errors++; $display("FAIL race_data got=%h exp=%h", word_data, exp_word); end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL race_timeout got=%b exp=0", timeout_err); end
    cycle(1'b0, 8'h00);
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL race_after got=%b/%b exp=0/0", timeout_err, busy); end
    checks++; if (word_count !== exp_count) begin errors++; $display("FAIL race_count got=%h exp=%h", word_count, exp_count); end
  endtask

  task automatic test_reset_mid_word();
    cycle(1'b1, 8'hAB);
    reset = 1'b1;
    cycle(1'b0, 8'h00);
    reset = 1'b0;
    exp_count = 8'h00;
    last_word = 16'h0000;
    checks++; if (busy !== 1'b0 || state_id !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", busy, state_id); end
    checks++; if (word_data !== 16'h0000 || word_count !== 8'h00) begin errors++; $display("FAIL rstmid_regs got=%h/%h exp=0000/00", word_data, word_count); end
    checks++; if (word_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses got=%b/%b exp=0/0", word_valid, timeout_err); end
    exp_q.push_back(16'hEFCD);
    cycle(1'b1, 8'hCD);
    cycle(1'b1, 8'hEF);
    exp_count++;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%b exp=1", word_valid); end
    else begin
      exp_word = exp_q.pop_front();
      last_word = exp_word;
      checks++; if (word_data !== exp_word) begin errors++; $display("FAIL rstmid_data got=%h exp=%h", word_data, exp_word); end
    end
    checks++; if (word_count !== exp_count) begin errors++; $display("FAIL rstmid_count got=%h exp=%h", word_count, exp_count); end
  endtask

  task automatic test_wrap();
    logic [7:0] lo, hi;
    int bad_data, bad_err, missing;
    bad_data = 0; bad_err = 0; missing = 0;
    reset = 1'b1;
    cycle(1'b0, 8'h00);
    reset = 1'b0;
    exp_count = 8'h00;
    for (int w = 0; w < 256; w++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      exp_q.push_back({hi, lo});
      cycle(1'b1, lo);
      if (timeout_err !== 1'b0) bad_err++;
      cycle(1'b1, hi);
      exp_count++;
      if (timeout_err !== 1'b0) bad_err++;
      if (word_valid !== 1'b1) missing++;
      else if (exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        if (word_data !== exp_word) bad_data++;
      end
      if (w == 254) begin
        checks++; if (word_count !== 8'hFF) begin errors++; $display("FAIL wrap_count_255 got=%h exp=ff", word_count); end
      end
    end
    checks++; if (word_count !== exp_count) begin errors++; $display("FAIL wrap_count got=%h exp=%h", word_count, exp_count); end
    checks++; if (missing != 0) begin errors++; $display("FAIL wrap_missing_valid got=%0d exp=0", missing); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL wrap_data got=%0d bad words exp=0", bad_data); end
    checks++; if (bad_err != 0) begin errors++; $display("FAIL wrap_timeout_err got=%0d exp=0", bad_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_expiry_race();
    test_reset_mid_word();
    test_wrap();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
